// File: rtl/coeff_code_encoder.sv
// Two-stage streaming encoder: signed coefficient -> {negate, marker, 3-bit mantissa, shift} code
// with valid/ready backpressure and per-frame last tagging.
module coeff_code_encoder #(
    parameter int DATA_W    = 10,
    parameter int FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_code,
    output logic              out_last,
    output logic              out_zero
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic              s1_valid;
    logic              s1_sign;
    logic [DATA_W-1:0] s1_mag;
    logic              s1_zero;
    logic              s1_last;
    logic [CNT_W-1:0]  frame_cnt;

    logic              s2_load;
    logic              in_fire;
    logic [DATA_W-1:0] in_mag;
    logic [3:0]        pos;
    logic [2:0]        mant;
    logic [9:0]        code_next;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // -512 negates to itself, which read as unsigned is exactly 512
    assign in_mag = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

    always_comb begin
        pos = '0;
        for (int i = 0; i < 10; i++) begin
            if (s1_mag[i]) pos = i[3:0];
        end
    end

    // Three bits directly below the leading one, zero-filled when fewer exist
    always_comb begin
        mant = 3'b000;
        case (pos)
            4'd0:    mant = 3'b000;
            4'd1:    mant = {s1_mag[0], 2'b00};
            4'd2:    mant = {s1_mag[1:0], 1'b0};
            4'd3:    mant = s1_mag[2:0];
            4'd4:    mant = s1_mag[3:1];
            4'd5:    mant = s1_mag[4:2];
            4'd6:    mant = s1_mag[5:3];
            4'd7:    mant = s1_mag[6:4];
            4'd8:    mant = s1_mag[7:5];
            4'd9:    mant = s1_mag[8:6];
            default: mant = 3'b000;
        endcase
    end

    assign code_next = s1_zero ? 10'h000 : {s1_sign, 1'b1, mant, 1'b0, pos};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_mag    <= '0;
            s1_zero   <= 1'b0;
            s1_last   <= 1'b0;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            out_code  <= 10'h000;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_sign   <= in_data[DATA_W-1];
                s1_mag    <= in_mag;
                s1_zero   <= (in_data == '0);
                s1_last   <= (frame_cnt == LAST_IDX);
                frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            // Output fields only change on a load, so they hold through a stall
            if (s2_load) begin
                out_valid <= 1'b1;
                out_code  <= code_next;
                out_last  <= s1_last;
                out_zero  <= s1_zero;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
